ebox_mem_req: RTL and testbench



---
 rtl/ebox_pkg.sv | 8 +
 rtl/ebox_mem_req.sv | 167 ++++++++++++++++
 tb/tb_ebox_mem_req.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ebox_pkg.sv
// ebox_pkg: shared state encoding, page-fail codes and widths for the EBOX memory request sequencer.
package ebox_pkg;
  localparam int VMA_W = 23;
  localparam int TIMEOUT_CYC = 64;
  localparam logic [0:10] PF_NONE = 11'h000;
  localparam logic [0:10] PF_TIMEOUT = 11'h7FF;
  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_PAUSE, S_DONE} state_t;
endpackage

// File: rtl/ebox_mem_req.sv
// ebox_mem_req: EBOX-side sequencer issuing read/write/read-pause-write requests to the MBOX.
// Define MEM_TIMEOUT_EN to abort a request with an NXM page fail after TIMEOUT_CYC cycles without ack.
module ebox_mem_req
  import ebox_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_mem_start,
  input  logic                 i_mem_read,
  input  logic                 i_mem_write,
  input  logic                 i_mem_rmw,
  input  logic [36-VMA_W:35]   i_mem_addr,
  input  logic                 i_mem_acref,
  input  logic [0:35]          i_mem_wdata,
  input  logic                 i_mem_resume,
  output logic                 o_mem_busy,
  output logic                 o_mem_done,
  output logic [0:35]          o_mem_rdata,
  output logic                 o_page_fail,
  output logic [0:10]          o_pf_code,
  output logic [36-VMA_W:35]   o_vma,
  output logic                 o_vma_acref,
  output logic                 o_req,
  output logic                 o_read,
  output logic                 o_write,
  output logic                 o_pse,
  output logic [0:35]          o_write_data,
  input  logic [0:35]          i_cache_data,
  input  logic [0:10]          i_pf_disp,
  input  logic                 i_mbox_ack
);
  state_t r_state, w_state;
  logic r_fail, w_fail;
  logic [0:35] r_rdata, w_rdata, r_wdata, w_wdata;
  logic [0:10] r_pf_code, w_pf_code;
  logic [36-VMA_W:35] r_vma, w_vma;
  logic r_acref, w_acref, r_req, w_req, r_read, w_read, r_write, w_write, r_pse, w_pse;
`ifdef MEM_TIMEOUT_EN
  logic [7:0] r_cnt, w_cnt;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_fail    <= 1'b0;
      r_rdata   <= '0;
      r_wdata   <= '0;
      r_pf_code <= '0;
      r_vma     <= '0;
      r_acref   <= 1'b0;
      r_req     <= 1'b0;
      r_read    <= 1'b0;
      r_write   <= 1'b0;
      r_pse     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      r_cnt     <= '0;
`endif
    end else begin
      r_state   <= w_state;
      r_fail    <= w_fail;
      r_rdata   <= w_rdata;
      r_wdata   <= w_wdata;
      r_pf_code <= w_pf_code;
      r_vma     <= w_vma;
      r_acref   <= w_acref;
      r_req     <= w_req;
      r_read    <= w_read;
      r_write   <= w_write;
      r_pse     <= w_pse;
`ifdef MEM_TIMEOUT_EN
      r_cnt     <= w_cnt;
`endif
    end
  end

  always_comb begin
    w_state   = r_state;
    w_fail    = r_fail;
    w_rdata   = r_rdata;
    w_wdata   = r_wdata;
    w_pf_code = r_pf_code;
    w_vma     = r_vma;
    w_acref   = r_acref;
    w_req     = r_req;
    w_read    = r_read;
    w_write   = r_write;
    w_pse     = r_pse;
`ifdef MEM_TIMEOUT_EN
    w_cnt     = 8'd0;
`endif
    case (r_state)
      S_IDLE: begin
        if (i_mem_start && (i_mem_rmw || i_mem_read || i_mem_write)) begin
          w_vma   = i_mem_addr;
          w_acref = i_mem_acref;
          w_fail  = 1'b0;
          w_req   = 1'b1;
          if (i_mem_rmw || i_mem_read) begin
            w_state = S_RD;
            w_read  = 1'b1;
            w_pse   = i_mem_rmw;
          end else begin
            w_state = S_WR;
            w_write = 1'b1;
            w_wdata = i_mem_wdata;
          end
        end
      end
      S_RD, S_WR: begin
        if (i_mbox_ack) begin
          w_req   = 1'b0;
          w_read  = 1'b0;
          w_write = 1'b0;
          if (i_pf_disp != PF_NONE) begin
            w_pse     = 1'b0;
            w_pf_code = i_pf_disp;
            w_fail    = 1'b1;
            w_state   = S_DONE;
          end else if (r_state == S_RD) begin
            w_rdata = i_cache_data;
            // an RMW keeps PSE asserted through the pause so the MBOX holds the line
            w_state = r_pse ? S_PAUSE : S_DONE;
          end else begin
            w_state = S_DONE;
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (r_cnt == 8'(TIMEOUT_CYC - 1)) begin
          w_req     = 1'b0;
          w_read    = 1'b0;
          w_write   = 1'b0;
          w_pse     = 1'b0;
          w_pf_code = PF_TIMEOUT;
          w_fail    = 1'b1;
          w_state   = S_DONE;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
`endif
      end
      S_PAUSE: begin
        if (i_mem_resume) begin
          w_wdata = i_mem_wdata;
          w_req   = 1'b1;
          w_write = 1'b1;
          w_pse   = 1'b0;
          w_state = S_WR;
        end
      end
      S_DONE: w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

  assign o_mem_busy   = r_state != S_IDLE;
  assign o_mem_done   = r_state == S_DONE;
  assign o_page_fail  = (r_state == S_DONE) && r_fail;
  assign o_mem_rdata  = r_rdata;
  assign o_pf_code    = r_pf_code;
  assign o_vma        = r_vma;
  assign o_vma_acref  = r_acref;
  assign o_req        = r_req;
  assign o_read       = r_read;
  assign o_write      = r_write;
  assign o_pse        = r_pse;
  assign o_write_data = r_wdata;
endmodule

// File: tb/tb_ebox_mem_req.sv
// tb_ebox_mem_req: randomized self-checking bench for ebox_mem_req with a transaction-level reference model.
module tb_ebox_mem_req;
  logic clk = 1'b0, reset = 1'b1;
  logic mem_start = 0, mem_read = 0, mem_write = 0, mem_rmw = 0, mem_acref = 0, mem_resume = 0, mbox_ack = 0;
  logic [13:35] mem_addr = '0;
  logic [0:35] mem_wdata = '0, cache_data = '0;
  logic [0:10] pf_disp = '0;
  logic mem_busy, mem_done, page_fail, vma_acref, req, rd, wr, pse;
  logic [0:35] mem_rdata, write_data;
  logic [0:10] pf_code;
  logic [13:35] vma;
  int checks = 0, errors = 0;
  logic [0:35] exp_rdata = '0;
  logic [0:10] exp_pf = '0;

  always #5 clk = ~clk;

  ebox_mem_req dut (
    .i_clk(clk), .i_reset(reset), .i_mem_start(mem_start), .i_mem_read(mem_read),
    .i_mem_write(mem_write), .i_mem_rmw(mem_rmw), .i_mem_addr(mem_addr), .i_mem_acref(mem_acref),
    .i_mem_wdata(mem_wdata), .i_mem_resume(mem_resume), .o_mem_busy(mem_busy), .o_mem_done(mem_done),
    .o_mem_rdata(mem_rdata), .o_page_fail(page_fail), .o_pf_code(pf_code), .o_vma(vma),
    .o_vma_acref(vma_acref), .o_req(req), .o_read(rd), .o_write(wr), .o_pse(pse),
    .o_write_data(write_data), .i_cache_data(cache_data), .i_pf_disp(pf_disp), .i_mbox_ack(mbox_ack)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({mem_busy, mem_done, page_fail, req, rd, wr, pse, vma_acref, mem_rdata, pf_code, vma, write_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b req=%b rdata=%h pf=%h vma=%h wd=%h exp all zero",
               mem_busy, mem_done, req, mem_rdata, pf_code, vma, write_data);
    end
    @(negedge clk);
    reset = 1'b0;
    step;
  endtask

  // op: 0 read, 1 write, 2 read-pause-write; dly = cycles after the issue cycle until ack
  task automatic run_txn(input int op, input logic [13:35] addr, input logic [0:35] wd, input logic [0:35] wd2,
                         input logic [0:35] cd, input logic [0:10] pf, input int dly, input int rdly);
    logic acr;
    logic [2:0] exp_bus;
    acr = 1'($urandom);
    exp_bus = {op != 1, op == 1, op == 2};
    mem_start = 1'b1;
    mem_rmw = (op == 2);
    mem_read = (op == 0) ? 1'b1 : (op == 2) ? 1'($urandom) : 1'b0;
    mem_write = (op == 1) ? 1'b1 : 1'($urandom);
    mem_addr = addr;
    mem_acref = acr;
    mem_wdata = wd;
    checks++;
    if (mem_busy !== 1'b0) begin errors++; $display("FAIL start_idle: busy=%b exp 0", mem_busy); end
    step;
    mem_start = 1'b0;
    mem_wdata = {$urandom, 4'($urandom)};
    mem_addr = 23'($urandom);
    checks++;
    if ({mem_busy, req, rd, wr, pse, vma, vma_acref} !== {1'b1, 1'b1, exp_bus, addr, acr}) begin
      errors++;
      $display("FAIL issue: got busy=%b req=%b r/w/pse=%b%b%b vma=%o acref=%b exp req=1 r/w/pse=%b vma=%o acref=%b",
               mem_busy, req, rd, wr, pse, vma, vma_acref, exp_bus, addr, acr);
    end
    if (op == 1) begin
      checks++;
      if (write_data !== wd) begin errors++; $display("FAIL write_data: got %o exp %o", write_data, wd); end
    end
    for (int k = 1; k <= dly; k++) begin
      step;
      checks++;
      if ({req, rd, wr, pse, mem_done} !== {1'b1, exp_bus, 1'b0}) begin
        errors++;
        $display("FAIL wait_stable: got req/r/w/pse/done=%b%b%b%b%b exp 1%b0", req, rd, wr, pse, mem_done, exp_bus);
      end
      mem_resume = 1'($urandom);
      cache_data = {$urandom, 4'($urandom)};
      pf_disp = 11'($urandom);
      if (k == dly) begin
        mbox_ack = 1'b1;
        cache_data = cd;
        pf_disp = pf;
      end
    end
    step;
    mbox_ack = 1'b0;
    mem_resume = 1'b0;
    if (pf != 11'h000) begin
      exp_pf = pf;
      checks++;
      if ({mem_done, page_fail, req, pse, pf_code, mem_rdata} !== {4'b1100, exp_pf, exp_rdata}) begin
        errors++;
        $display("FAIL page_fail: got done=%b pf=%b req=%b pse=%b code=%o rdata=%o exp 1100 code=%o rdata=%o",
                 mem_done, page_fail, req, pse, pf_code, mem_rdata, exp_pf, exp_rdata);
      end
    end else if (op == 2) begin
      exp_rdata = cd;
      for (int k = 0; k <= rdly; k++) begin
        checks++;
        if ({mem_busy, mem_done, req, rd, wr, pse, mem_rdata} !== {6'b100001, exp_rdata}) begin
          errors++;
          $display("FAIL pause: got busy/done/req/r/w/pse=%b%b%b%b%b%b rdata=%o exp 100001 rdata=%o",
                   mem_busy, mem_done, req, rd, wr, pse, mem_rdata, exp_rdata);
        end
        if (k == rdly) begin
          mem_resume = 1'b1;
          mem_wdata = wd2;
        end
        step;
      end
      mem_resume = 1'b0;
      mem_wdata = {$urandom, 4'($urandom)};
      checks++;
      if ({req, rd, wr, pse, write_data} !== {4'b1010, wd2}) begin
        errors++;
        $display("FAIL resume_write: got req/r/w/pse=%b%b%b%b wd=%o exp 1010 wd=%o", req, rd, wr, pse, write_data, wd2);
      end
      for (int k = 1; k <= dly; k++) begin
        step;
        checks++;
        if ({req, wr, pse, mem_done} !== 4'b1100) begin
          errors++;
          $display("FAIL rmw_write_wait: got req/w/pse/done=%b%b%b%b exp 1100", req, wr, pse, mem_done);
        end
        if (k == dly) mbox_ack = 1'b1;
        pf_disp = (k == dly) ? 11'h000 : 11'($urandom);
      end
      step;
      mbox_ack = 1'b0;
      checks++;
      if ({mem_done, page_fail, req, mem_rdata, pf_code} !== {3'b100, exp_rdata, exp_pf}) begin
        errors++;
        $display("FAIL rmw_done: got done=%b pf=%b req=%b rdata=%o code=%o exp 100 rdata=%o code=%o",
                 mem_done, page_fail, req, mem_rdata, pf_code, exp_rdata, exp_pf);
      end
    end else begin
      if (op == 0) exp_rdata = cd;
      checks++;
      if ({mem_done, page_fail, req, rd, wr, mem_rdata, pf_code} !== {5'b10000, exp_rdata, exp_pf}) begin
        errors++;
        $display("FAIL done: got done=%b pf=%b req=%b rdata=%o code=%o exp 10 req=0 rdata=%o code=%o",
                 mem_done, page_fail, req, mem_rdata, pf_code, exp_rdata, exp_pf);
      end
    end
    step;
    checks++;
    if ({mem_done, mem_busy, page_fail} !== 3'b000) begin
      errors++;
      $display("FAIL back_idle: got done=%b busy=%b pf=%b exp 000", mem_done, mem_busy, page_fail);
    end
  endtask

  task automatic test_read;
    run_txn(0, 23'o0001000, '0, '0, 36'o123456701234, 11'h000, 2, 0);
  endtask

  task automatic test_write;
    run_txn(1, 23'o0004321, 36'o777000111222, '0, '0, 11'h000, 3, 0);
  endtask

  task automatic test_rmw;
    run_txn(2, 23'o0000777, '0, 36'o6, 36'o5, 11'h000, 1, 3);
  endtask

  task automatic test_page_fail;
    run_txn(0, 23'o0002000, '0, '0, 36'o111111111111, 11'o0421, 2, 0);
    run_txn(2, 23'o0002001, '0, 36'o7, 36'o222, 11'o0033, 1, 0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 30; n++) begin
      logic [0:10] pf;
      pf = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(1, 2047)) : 11'h000;
      run_txn(int'($urandom_range(0, 2)), 23'($urandom), {$urandom, 4'($urandom)}, {$urandom, 4'($urandom)},
              {$urandom, 4'($urandom)}, pf, int'($urandom_range(1, 5)), int'($urandom_range(0, 4)));
    end
  endtask

  task automatic test_busy;
    mem_start = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_rmw = 1'b0; mem_addr = 23'o1234567;
    step;
    mem_start = 1'b0;
    step;
    mem_start = 1'b1; mem_read = 1'b0; mem_write = 1'b1; mem_addr = 23'o7654321;
    step;
    mem_start = 1'b0;
    checks++;
    if ({vma, rd, wr} !== {23'o1234567, 2'b10}) begin
      errors++;
      $display("FAIL busy_ignore: got vma=%o r/w=%b%b exp vma=1234567 r/w=10", vma, rd, wr);
    end
    mbox_ack = 1'b1; cache_data = 36'o246; pf_disp = 11'h000;
    step;
    mbox_ack = 1'b0;
    exp_rdata = 36'o246;
    checks++;
    if ({mem_done, mem_rdata} !== {1'b1, exp_rdata}) begin
      errors++;
      $display("FAIL busy_done: got done=%b rdata=%o exp 1 rdata=%o", mem_done, mem_rdata, exp_rdata);
    end
    step;
  endtask

  task automatic test_idle_strobes;
    mem_resume = 1'b1;
    step;
    mem_resume = 1'b0;
    mem_start = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_rmw = 1'b0;
    step;
    mem_start = 1'b0;
    checks++;
    if ({mem_busy, req, rd, wr, mem_done} !== 5'b00000) begin
      errors++;
      $display("FAIL idle_ignore: got busy/req/r/w/done=%b%b%b%b%b exp 00000", mem_busy, req, rd, wr, mem_done);
    end
    step;
  endtask

  task automatic test_reset_mid;
    int done_seen = 0;
    mem_start = 1'b1; mem_write = 1'b1; mem_read = 1'b0; mem_rmw = 1'b0; mem_wdata = 36'o525252;
    step;
    mem_start = 1'b0;
    step;
    #2 reset = 1'b1;
    #1;
    exp_rdata = '0;
    exp_pf = '0;
    checks++;
    if ({req, wr, mem_busy, mem_rdata, pf_code, write_data} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got req=%b w=%b busy=%b rdata=%o code=%o wd=%o exp all zero",
               req, wr, mem_busy, mem_rdata, pf_code, write_data);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step;
      if (mem_done || mem_busy) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin errors++; $display("FAIL reset_no_done: got %0d busy/done cycles exp 0", done_seen); end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout;
    int n = 0;
    mem_start = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_rmw = 1'b0;
    step;
    mem_start = 1'b0;
    while (!mem_done && n < 300) begin
      step;
      n++;
    end
    exp_pf = 11'h7FF;
    checks++;
    if ({n, page_fail, req, pf_code} !== {ebox_pkg::TIMEOUT_CYC, 2'b10, exp_pf}) begin
      errors++;
      $display("FAIL timeout: got cycles=%0d pf=%b req=%b code=%h exp cycles=%0d pf=1 code=%h",
               n, page_fail, req, pf_code, ebox_pkg::TIMEOUT_CYC, exp_pf);
    end
    step;
  endtask
`endif

  initial begin
    test_reset;
    test_read;
    test_write;
    test_rmw;
    test_page_fail;
    test_busy;
    test_idle_strobes;
    test_random;
    test_reset_mid;
`ifdef MEM_TIMEOUT_EN
    test_timeout;
`endif
    test_read;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
